dose_scheduler: RTL and testbench

DOSE_SCHEDULER -- requirements
Module: dose_scheduler

---
 rtl/dose_scheduler_pkg.sv | 37 +++
 rtl/dose_scheduler_if.sv | 24 ++
 rtl/dose_slot_table.sv | 36 +++
 rtl/dose_scheduler.sv | 146 ++++++++++++++
 tb/tb_dose_scheduler.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dose_scheduler_pkg.sv
// Shared types and constants for the dose scheduler: FSM states, alarm codes
// and the packed log record layout.
package dose_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DUE  = 2'd2,
    ST_LOG  = 2'd3
  } state_t;

  localparam logic [1:0] ALARM_OFF = 2'b00;
  localparam logic [1:0] ALARM_DUE = 2'b01;
  localparam logic [1:0] ALARM_ESC = 2'b10;

  // Log record: {missed, slot[2:0], dose_time[7:0]}
  localparam int unsigned LOG_W          = 12;
  localparam int unsigned LOG_TIME_LSB   = 0;
  localparam int unsigned LOG_TIME_W     = 8;
  localparam int unsigned LOG_SLOT_LSB   = 8;
  localparam int unsigned LOG_SLOT_W     = 3;
  localparam int unsigned LOG_MISSED_BIT = 11;

  function automatic logic [LOG_W-1:0] pack_log(
    input logic                  missed,
    input logic [LOG_SLOT_W-1:0] slot,
    input logic [LOG_TIME_W-1:0] dose_time
  );
    logic [LOG_W-1:0] r;
    r = '0;
    r[LOG_MISSED_BIT]                  = missed;
    r[LOG_SLOT_LSB +: LOG_SLOT_W]      = slot;
    r[LOG_TIME_LSB +: LOG_TIME_W]      = dose_time;
    return r;
  endfunction

endpackage

// File: rtl/dose_scheduler_if.sv
// Configuration write port and logger handshake of the dose scheduler.
interface dose_scheduler_if #(
  parameter int NUM_SLOTS = 8
);
  localparam int AW = $clog2(NUM_SLOTS);

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_time;
  logic          cfg_en;
  logic          log_req;
  logic [11:0]   log_rec;
  logic          log_gnt;

  modport master (
    output cfg_we, cfg_addr, cfg_time, cfg_en, log_gnt,
    input  log_req, log_rec
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_time, cfg_en, log_gnt,
    output log_req, log_rec
  );
endinterface

// File: rtl/dose_slot_table.sv
// NUM_SLOTS x {en, time} register file: one write port, one combinational read.
module dose_slot_table #(
  parameter int NUM_SLOTS = 8,
  parameter int AW        = $clog2(NUM_SLOTS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wtime,
  input  logic          wen,
  input  logic [AW-1:0] raddr,
  output logic          rd_en,
  output logic [7:0]    rd_time
);

  logic [NUM_SLOTS-1:0] en_q;
  logic [7:0]           time_q [NUM_SLOTS];

  // Slot storage; reset leaves every slot disabled at time 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int unsigned i = 0; i < unsigned'(NUM_SLOTS); i++) begin
        time_q[i] <= '0;
      end
    end else if (we) begin
      en_q[waddr]   <= wen;
      time_q[waddr] <= wtime;
    end
  end

  assign rd_en   = en_q[raddr];
  assign rd_time = time_q[raddr];

endmodule

// File: rtl/dose_scheduler.sv
// Dose scheduler: time base, slot scan FSM, due/escalate/miss alarm and logger handshake.
module dose_scheduler
  import dose_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int ESC_TICKS  = 4,
  parameter int MISS_TICKS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         tick,
  input  logic                         ack,
  dose_scheduler_if.slave              bus,
  output logic [7:0]                   now,
  output logic [1:0]                   alarm,
  output logic [$clog2(NUM_SLOTS)-1:0] due_slot,
  output logic                         busy
);

  localparam int AW    = $clog2(NUM_SLOTS);
  localparam int CNT_W = $clog2(MISS_TICKS + 1);
  localparam logic [AW-1:0]    LAST     = AW'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] ESC_CNT  = CNT_W'(ESC_TICKS);
  localparam logic [CNT_W-1:0] MISS_CNT = CNT_W'(MISS_TICKS);

  state_t             state_q, state_n;
  logic [7:0]         now_q;
  logic [AW-1:0]      scan_idx_q, scan_idx_n;
  logic [7:0]         scan_time_q, scan_time_n;
  logic [AW-1:0]      svc_slot_q, svc_slot_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               esc_q, esc_n;
  logic               pending_q, pending_n;
  logic [LOG_W-1:0]   log_rec_q, log_rec_n;
  logic               rd_en;
  logic [7:0]         rd_time;

  dose_slot_table #(
    .NUM_SLOTS(NUM_SLOTS),
    .AW       (AW)
  ) u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bus.cfg_we & ena),
    .waddr  (bus.cfg_addr),
    .wtime  (bus.cfg_time),
    .wen    (bus.cfg_en),
    .raddr  (scan_idx_q),
    .rd_en  (rd_en),
    .rd_time(rd_time)
  );

  // Next-state and next-register values for the scan/alarm/log sequence
  always_comb begin
    state_n     = state_q;
    scan_idx_n  = scan_idx_q;
    scan_time_n = scan_time_q;
    svc_slot_n  = svc_slot_q;
    cnt_n       = cnt_q;
    esc_n       = esc_q;
    pending_n   = pending_q;
    log_rec_n   = log_rec_q;

    if (tick && state_q != ST_IDLE) pending_n = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (tick || pending_q) begin
          state_n     = ST_SCAN;
          // a pending tick already advanced now_q; a live tick is post-incremented here
          scan_time_n = tick ? now_q + 8'd1 : now_q;
          scan_idx_n  = '0;
          pending_n   = 1'b0;
        end
      end
      ST_SCAN: begin
        if (rd_en && rd_time == scan_time_q) begin
          state_n    = ST_DUE;
          svc_slot_n = scan_idx_q;
          cnt_n      = '0;
          esc_n      = 1'b0;
        end else if (scan_idx_q == LAST) begin
          state_n = ST_IDLE;
        end else begin
          scan_idx_n = scan_idx_q + AW'(1);
        end
      end
      ST_DUE: begin
        if (tick && cnt_q != '1) cnt_n = cnt_q + CNT_W'(1);
        if (cnt_n >= ESC_CNT) esc_n = 1'b1;
        if (ack) begin
          state_n   = ST_LOG;
          log_rec_n = pack_log(1'b0, LOG_SLOT_W'(svc_slot_q), scan_time_q);
        end else if (cnt_n >= MISS_CNT) begin
          state_n   = ST_LOG;
          log_rec_n = pack_log(1'b1, LOG_SLOT_W'(svc_slot_q), scan_time_q);
        end
      end
      ST_LOG: begin
        if (bus.log_gnt) begin
          if (svc_slot_q == LAST) begin
            state_n = ST_IDLE;
          end else begin
            state_n    = ST_SCAN;
            scan_idx_n = svc_slot_q + AW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State registers; everything freezes while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      now_q       <= '0;
      scan_idx_q  <= '0;
      scan_time_q <= '0;
      svc_slot_q  <= '0;
      cnt_q       <= '0;
      esc_q       <= 1'b0;
      pending_q   <= 1'b0;
      log_rec_q   <= '0;
    end else if (ena) begin
      state_q     <= state_n;
      if (tick) now_q <= now_q + 8'd1;
      scan_idx_q  <= scan_idx_n;
      scan_time_q <= scan_time_n;
      svc_slot_q  <= svc_slot_n;
      cnt_q       <= cnt_n;
      esc_q       <= esc_n;
      pending_q   <= pending_n;
      log_rec_q   <= log_rec_n;
    end
  end

  assign now         = now_q;
  assign alarm       = (state_q == ST_DUE) ? (esc_q ? ALARM_ESC : ALARM_DUE) : ALARM_OFF;
  assign due_slot    = svc_slot_q;
  assign busy        = (state_q != ST_IDLE);
  assign bus.log_req = (state_q == ST_LOG);
  assign bus.log_rec = log_rec_q;

endmodule

// File: tb/tb_dose_scheduler.sv
// Scoreboard bench for dose_scheduler: expected log records are queued when
// the stimulus that causes them is driven and popped when the logger is served.
module tb_dose_scheduler;

  localparam int NUM_SLOTS = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       tick;
  logic       ack;
  logic [7:0] now;
  logic [1:0] alarm;
  logic [2:0] due_slot;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q [$];

  dose_scheduler_if #(.NUM_SLOTS(NUM_SLOTS)) bus ();

  dose_scheduler #(
    .NUM_SLOTS (NUM_SLOTS),
    .ESC_TICKS (4),
    .MISS_TICKS(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .tick    (tick),
    .ack     (ack),
    .bus     (bus.slave),
    .now     (now),
    .alarm   (alarm),
    .due_slot(due_slot),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] rec(input logic m, input logic [2:0] s, input logic [7:0] t);
    return {m, s, t};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge
  task automatic pulse_tick(input int gap);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic tick_with_ack();
    tick = 1'b1;
    ack  = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    ack  = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [7:0] t, input logic en);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_time = t;
    bus.cfg_en   = en;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_alarm(input string tag, input logic [1:0] exp, input int budget);
    for (int i = 0; i < budget && alarm !== exp; i++) @(negedge clk);
    check_eq(tag, alarm, exp);
  endtask

  task automatic service_log(input string tag);
    logic [11:0] exp;
    for (int i = 0; i < 40 && bus.log_req !== 1'b1; i++) @(negedge clk);
    check_eq({tag, "_req"}, bus.log_req, 1);
    check_eq({tag, "_alarm"}, alarm, 2'b00);
    check_eq({tag, "_sbq"}, (exp_q.size() > 0), 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
    check_eq({tag, "_rec"}, bus.log_rec, exp);
    repeat (2) @(negedge clk);
    check_eq({tag, "_hold"}, bus.log_req, 1);
    check_eq({tag, "_stable"}, bus.log_rec, exp);
    bus.log_gnt = 1'b1;
    @(negedge clk);
    bus.log_gnt = 1'b0;
    check_eq({tag, "_drop"}, bus.log_req, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    ena          = 1'b1;
    tick         = 1'b0;
    ack          = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_time = '0;
    bus.cfg_en   = 1'b0;
    bus.log_gnt  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_now", now, 0);
    check_eq("rst_alarm", alarm, 0);
    check_eq("rst_log_req", bus.log_req, 0);
    check_eq("rst_log_rec", bus.log_rec, 0);
    check_eq("rst_due_slot", due_slot, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Slot 2 at time 5, never acked: escalate then miss
    cfg_write(3'd2, 8'd5, 1'b1);
    for (int i = 0; i < 4; i++) pulse_tick(10);
    check_eq("pre_alarm", alarm, 0);
    pulse_tick(0);
    wait_alarm("a_due", 2'b01, NUM_SLOTS + 4);
    check_eq("a_due_slot", due_slot, 2);
    check_eq("a_now", now, 5);
    check_eq("a_busy", busy, 1);
    for (int i = 0; i < 3; i++) pulse_tick(1);
    check_eq("a_esc_early", alarm, 2'b01);
    pulse_tick(1);
    check_eq("a_esc", alarm, 2'b10);
    for (int i = 0; i < 11; i++) pulse_tick(1);
    check_eq("a_miss_early", bus.log_req, 0);
    check_eq("a_esc_hold", alarm, 2'b10);
    exp_q.push_back(rec(1'b1, 3'd2, 8'd5));
    pulse_tick(0);
    service_log("a_log");
    repeat (25) @(negedge clk);
    check_eq("a_idle_now", now, 21);

    // Slot 2 moved to time 22; ack coincides with the 16th tick
    cfg_write(3'd2, 8'd22, 1'b1);
    pulse_tick(0);
    wait_alarm("b_due", 2'b01, NUM_SLOTS + 4);
    for (int i = 0; i < 15; i++) pulse_tick(1);
    check_eq("b_miss_early", bus.log_req, 0);
    exp_q.push_back(rec(1'b0, 3'd2, 8'd22));
    tick_with_ack();
    service_log("b_log");
    repeat (25) @(negedge clk);
    check_eq("b_now", now, 38);

    // Slots 1 and 6 share time 40; tick during DUE rescans at 41 and finds slot 3
    cfg_write(3'd2, 8'd22, 1'b0);
    cfg_write(3'd1, 8'd40, 1'b1);
    cfg_write(3'd6, 8'd40, 1'b1);
    cfg_write(3'd3, 8'd41, 1'b1);
    pulse_tick(12);
    check_eq("c_no_match", alarm, 0);
    pulse_tick(0);
    wait_alarm("c_due1", 2'b01, NUM_SLOTS + 4);
    check_eq("c_slot1", due_slot, 1);
    pulse_tick(1);
    exp_q.push_back(rec(1'b0, 3'd1, 8'd40));
    do_ack();
    service_log("c_log1");
    wait_alarm("c_due6", 2'b01, 20);
    check_eq("c_slot6", due_slot, 6);
    exp_q.push_back(rec(1'b0, 3'd6, 8'd40));
    do_ack();
    service_log("c_log6");
    wait_alarm("c_due3", 2'b01, 30);
    check_eq("c_slot3", due_slot, 3);
    exp_q.push_back(rec(1'b0, 3'd3, 8'd41));
    do_ack();
    service_log("c_log3");
    repeat (20) @(negedge clk);

    // Wrap 255 -> 0; slot 5 at time 0 fires
    cfg_write(3'd1, 8'd40, 1'b0);
    cfg_write(3'd6, 8'd40, 1'b0);
    cfg_write(3'd3, 8'd41, 1'b0);
    cfg_write(3'd5, 8'd0, 1'b1);
    tick = 1'b1;
    repeat (214) @(negedge clk);
    tick = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("d_now255", now, 255);
    check_eq("d_idle_alarm", alarm, 0);
    do_ack();
    check_eq("d_ack_idle_busy", busy, 0);
    check_eq("d_ack_idle_req", bus.log_req, 0);
    pulse_tick(0);
    check_eq("d_now0", now, 0);
    wait_alarm("d_due", 2'b01, NUM_SLOTS + 4);
    check_eq("d_slot5", due_slot, 5);
    exp_q.push_back(rec(1'b0, 3'd5, 8'd0));
    do_ack();
    service_log("d_log");
    repeat (20) @(negedge clk);

    // Reset while a record is waiting for grant
    cfg_write(3'd7, 8'd1, 1'b1);
    pulse_tick(0);
    wait_alarm("e_due", 2'b01, NUM_SLOTS + 4);
    check_eq("e_slot7", due_slot, 7);
    do_ack();
    check_eq("e_req", bus.log_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("e_rst_req", bus.log_req, 0);
    check_eq("e_rst_alarm", alarm, 0);
    check_eq("e_rst_busy", busy, 0);
    check_eq("e_rst_now", now, 0);
    check_eq("e_rst_slot", due_slot, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_tick(15);
    check_eq("e_cleared_alarm", alarm, 0);
    check_eq("e_cleared_req", bus.log_req, 0);
    check_eq("e_now1", now, 1);
    check_eq("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
